// File: rtl/arm_const_pkg.sv
// ---------------------------------------------------------------------------
// arm_const : shared constants and types for the ARM core data-memory path.
//
// Contents:
//   dmem_state_e  - state of the VRAM clear engine (DMEM_IDLE, DMEM_CLEAR)
//   dmem_region_e - memory region selected by a CPU address (REG_DRAM, REG_VRAM)
//   dmem_be_w()   - number of byte lanes in a data word of a given width
//   DMEM_BE_W     - byte-lane count for the default 32-bit data word
// ---------------------------------------------------------------------------
package arm_const;

    typedef enum logic {
        DMEM_IDLE  = 1'b0,
        DMEM_CLEAR = 1'b1
    } dmem_state_e;

    typedef enum logic {
        REG_DRAM = 1'b0,
        REG_VRAM = 1'b1
    } dmem_region_e;

    localparam int DMEM_DATA_W = 32;

    function automatic int dmem_be_w(input int data_w);
        return data_w / 8;
    endfunction

    localparam int DMEM_BE_W = dmem_be_w(DMEM_DATA_W);

endpackage

// File: rtl/data_mem_ctrl_dmem_bank.sv
// ---------------------------------------------------------------------------
// dmem_bank : byte-lane RAM with one write port, one enabled read port (A)
// and one free-running read port (B). Both reads are registered and
// read-first: a write on the same edge is not visible until the next read.
// Memory contents are never reset; only the read registers are.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset (read regs only)
//   we, be, waddr, wd write strobe, lane enables, word address, lane data
//   re_a, raddr_a     port A read enable / address
//   q_a               port A read data (holds when re_a=0)
//   raddr_b, q_b      port B address / read data (updates every cycle)
// ---------------------------------------------------------------------------
module dmem_bank #(
    parameter int DEPTH  = 16384,
    parameter int BE_W   = 4,
    parameter int LANE_W = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         we,
    input  logic [BE_W-1:0]              be,
    input  logic [AW-1:0]                waddr,
    input  logic [BE_W-1:0][LANE_W-1:0]  wd,
    input  logic                         re_a,
    input  logic [AW-1:0]                raddr_a,
    output logic [BE_W-1:0][LANE_W-1:0]  q_a,
    input  logic [AW-1:0]                raddr_b,
    output logic [BE_W-1:0][LANE_W-1:0]  q_b
);

    logic [BE_W-1:0][LANE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[waddr][i] <= wd[i];
                end
            end
        end
    end

    // stage p1: registered read outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_a <= '0;
            q_b <= '0;
        end else begin
            if (re_a) begin
                q_a <= mem[raddr_a];
            end
            q_b <= mem[raddr_b];
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl : CPU data-memory controller for the ARM core.
//
// Decodes CPU word addresses into a DRAM region (a[SEL_BIT]=0) and a VRAM
// region (a[SEL_BIT]=1), performs byte-enable writes and one-cycle registered
// reads, exposes a registered video read port on VRAM, and runs a VRAM clear
// engine after reset (CLEAR_ON_RESET) and on clr_req.
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   en, we       CPU access strobe, write(1)/read(0)
//   be, a, wd    byte enables, word address, write data
//   rd, rd_valid registered read data (holds), one-cycle valid pulse
//   fault        one-cycle pulse for a dropped access
//   busy         clear engine running
//   clr_req      start / restart a VRAM clear
//   vga_a        video read address
//   vga_rd       video read data (latency 1, read-first)
//   parity_err   parity mismatch on a CPU read (only with DMEM_PARITY_EN)
//
// Build option: define DMEM_PARITY_EN to store an even-parity bit per byte.
// ---------------------------------------------------------------------------
module data_mem_ctrl
    import arm_const::*;
#(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                RAM_DEPTH      = 16384,
    parameter int                VRAM_DEPTH     = 16384,
    parameter int                SEL_BIT        = 14,
    parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0,
    parameter bit                CLEAR_ON_RESET = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          we,
    input  logic [DATA_W/8-1:0]           be,
    input  logic [ADDR_W-1:0]             a,
    input  logic [DATA_W-1:0]             wd,
    output logic [DATA_W-1:0]             rd,
    output logic                          rd_valid,
    output logic                          fault,
`ifdef DMEM_PARITY_EN
    output logic                          parity_err,
`endif
    output logic                          busy,
    input  logic                          clr_req,
    input  logic [$clog2(VRAM_DEPTH)-1:0] vga_a,
    output logic [DATA_W-1:0]             vga_rd
);

    localparam int BE_W    = dmem_be_w(DATA_W);
    localparam int RAM_AW  = $clog2(RAM_DEPTH);
    localparam int VRAM_AW = $clog2(VRAM_DEPTH);
`ifdef DMEM_PARITY_EN
    localparam int LANE_W  = 9;
`else
    localparam int LANE_W  = 8;
`endif

    typedef logic [BE_W-1:0][LANE_W-1:0] lanes_t;

    // Split a data word into stored byte lanes (parity bit on top if enabled).
    function automatic lanes_t pack_lanes(input logic [DATA_W-1:0] d);
        lanes_t l;
        for (int i = 0; i < BE_W; i++) begin
`ifdef DMEM_PARITY_EN
            l[i] = {^d[8*i +: 8], d[8*i +: 8]};
`else
            l[i] = d[8*i +: 8];
`endif
        end
        return l;
    endfunction

    function automatic logic [DATA_W-1:0] lane_data(input lanes_t l);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < BE_W; i++) begin
            d[8*i +: 8] = l[i][7:0];
        end
        return d;
    endfunction

`ifdef DMEM_PARITY_EN
    function automatic logic lane_parity_bad(input lanes_t l);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < BE_W; i++) begin
            bad = bad | (l[i][8] ^ (^l[i][7:0]));
        end
        return bad;
    endfunction
`endif

    // ---------------- stage p0: address decode ----------------
    dmem_region_e       region;
    logic [SEL_BIT-1:0] idx;
    logic               upper_set;
    logic               out_of_range;
    logic               addr_ok;
    logic               cpu_rd;
    logic               cpu_dram_we;
    logic               cpu_vram_we;
    logic               vram_blocked;
    logic               fault_p0;

    assign idx       = a[SEL_BIT-1:0];
    assign region    = a[SEL_BIT] ? REG_VRAM : REG_DRAM;
    assign upper_set = (a >> (SEL_BIT + 1)) != '0;

    always_comb begin
        out_of_range = 1'b0;
        if (region == REG_VRAM) begin
            out_of_range = int'(idx) >= VRAM_DEPTH;
        end else begin
            out_of_range = int'(idx) >= RAM_DEPTH;
        end
    end

    assign addr_ok      = !upper_set && !out_of_range;
    assign cpu_rd       = en && !we && addr_ok;
    assign cpu_dram_we  = en && we && addr_ok && (region == REG_DRAM);
    // While clearing, the engine owns the VRAM write port; CPU VRAM writes lose.
    assign vram_blocked = en && we && addr_ok && (region == REG_VRAM) && busy;
    assign cpu_vram_we  = en && we && addr_ok && (region == REG_VRAM) && !busy;
    assign fault_p0     = (en && !addr_ok) || vram_blocked;

    // ---------------- clear engine ----------------
    dmem_state_e        state, state_nxt;
    logic [VRAM_AW-1:0] clr_cnt, clr_cnt_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= CLEAR_ON_RESET ? DMEM_CLEAR : DMEM_IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            DMEM_IDLE: begin
                if (clr_req) begin
                    state_nxt   = DMEM_CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            DMEM_CLEAR: begin
                if (clr_req) begin
                    clr_cnt_nxt = '0;
                end else if (clr_cnt == VRAM_AW'(VRAM_DEPTH - 1)) begin
                    state_nxt   = DMEM_IDLE;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt   = DMEM_IDLE;
                clr_cnt_nxt = '0;
            end
        endcase
    end

    assign busy = (state == DMEM_CLEAR);

    // ---------------- memory banks ----------------
    logic               vram_we;
    logic [BE_W-1:0]    vram_be;
    logic [VRAM_AW-1:0] vram_waddr;
    lanes_t             vram_wd;
    lanes_t             dram_qa, dram_qb_unused, vram_qa, vram_qb;

    assign vram_we    = busy || cpu_vram_we;
    assign vram_be    = busy ? '1 : be;
    assign vram_waddr = busy ? clr_cnt : idx[VRAM_AW-1:0];
    assign vram_wd    = busy ? pack_lanes(CLEAR_VALUE) : pack_lanes(wd);

    dmem_bank #(
        .DEPTH  (RAM_DEPTH),
        .BE_W   (BE_W),
        .LANE_W (LANE_W)
    ) u_dram (
        .clk     (clk),
        .reset   (reset),
        .we      (cpu_dram_we),
        .be      (be),
        .waddr   (idx[RAM_AW-1:0]),
        .wd      (pack_lanes(wd)),
        .re_a    (cpu_rd && (region == REG_DRAM)),
        .raddr_a (idx[RAM_AW-1:0]),
        .q_a     (dram_qa),
        .raddr_b ('0),
        .q_b     (dram_qb_unused)
    );

    dmem_bank #(
        .DEPTH  (VRAM_DEPTH),
        .BE_W   (BE_W),
        .LANE_W (LANE_W)
    ) u_vram (
        .clk     (clk),
        .reset   (reset),
        .we      (vram_we),
        .be      (vram_be),
        .waddr   (vram_waddr),
        .wd      (vram_wd),
        .re_a    (cpu_rd && (region == REG_VRAM)),
        .raddr_a (idx[VRAM_AW-1:0]),
        .q_a     (vram_qa),
        .raddr_b (vga_a),
        .q_b     (vram_qb)
    );

    // ---------------- stage p1: read return and fault ----------------
    logic         rd_vld_p1;
    dmem_region_e rd_region_p1;
    logic         fault_p1;
    lanes_t       rd_lanes_p1;

    // rd_region_p1 only moves on a legal read, so rd keeps the last read word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_vld_p1    <= 1'b0;
            rd_region_p1 <= REG_DRAM;
            fault_p1     <= 1'b0;
        end else begin
            rd_vld_p1 <= cpu_rd;
            fault_p1  <= fault_p0;
            if (cpu_rd) begin
                rd_region_p1 <= region;
            end
        end
    end

    assign rd_lanes_p1 = (rd_region_p1 == REG_VRAM) ? vram_qa : dram_qa;
    assign rd          = lane_data(rd_lanes_p1);
    assign rd_valid    = rd_vld_p1;
    assign fault       = fault_p1;
    assign vga_rd      = lane_data(vram_qb);

`ifdef DMEM_PARITY_EN
    assign parity_err  = rd_vld_p1 && lane_parity_bad(rd_lanes_p1);
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        we;
    logic [3:0]  be;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        rd_valid;
    logic        fault;
    logic        busy;
    logic        clr_req;
    logic [13:0] vga_a;
    logic [31:0] vga_rd;

    always #5 clk = ~clk;

    data_mem_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .we       (we),
        .be       (be),
        .a        (a),
        .wd       (wd),
        .rd       (rd),
        .rd_valid (rd_valid),
        .fault    (fault),
        .busy     (busy),
        .clr_req  (clr_req),
        .vga_a    (vga_a),
        .vga_rd   (vga_rd)
    );

    int tests = 0;
    int fails = 0;
    int busy_cycles = 0;

    // Reference model: plain word arrays, busy flag managed by the sequence.
    logic [31:0] dmem_m [16384];
    logic [31:0] vmem_m [16384];
    logic [31:0] exp_rd = '0;
    bit          m_busy = 1'b0;

    logic [31:0] pool [8];
    logic [31:0] addr;
    int          n;
    int          k;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (busy === 1'b1) busy_cycles++;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16384; i++) vmem_m[i] = 32'h0;
    endtask

    // One CPU cycle: predict from the model, clock it, compare, update model.
    task automatic access(input string tag, input bit e, input bit w, input logic [3:0] b,
                          input logic [31:0] ad, input logic [31:0] d, input logic [13:0] va);
        logic        exp_vld;
        logic        exp_flt;
        logic [31:0] exp_vga;
        bit          legal;
        bit          isv;
        int          ix;
        en = e; we = w; be = b; a = ad; wd = d; vga_a = va;
        legal   = (ad >> 15) == 32'h0;
        isv     = ad[14];
        ix      = int'(ad[13:0]);
        exp_vga = vmem_m[va];
        exp_vld = 1'b0;
        exp_flt = 1'b0;
        if (e) begin
            if (!legal) exp_flt = 1'b1;
            else if (w) begin
                if (isv && m_busy) exp_flt = 1'b1;
                else if (isv) vmem_m[ix] = merge(vmem_m[ix], d, b);
                else dmem_m[ix] = merge(dmem_m[ix], d, b);
            end else begin
                exp_vld = 1'b1;
                exp_rd  = isv ? vmem_m[ix] : dmem_m[ix];
            end
        end
        tick();
        en = 1'b0; we = 1'b0;
        check({tag, "_vld"}, {31'h0, rd_valid}, {31'h0, exp_vld});
        check({tag, "_fault"}, {31'h0, fault}, {31'h0, exp_flt});
        check({tag, "_rd"}, rd, exp_rd);
        if (!m_busy) check({tag, "_vga"}, vga_rd, exp_vga);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; we = 1'b0; be = '0; a = '0; wd = '0;
        clr_req = 1'b0; vga_a = '0;
        repeat (3) tick();

        // Reset state
        check("rst_rd", rd, 32'h0);
        check("rst_vld", {31'h0, rd_valid}, 32'h0);
        check("rst_fault", {31'h0, fault}, 32'h0);
        check("rst_vga", vga_rd, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h1);

        // Automatic clear after reset release
        reset = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 20000) begin n++; tick(); end
        check("boot_busy_len", n, 16384);
        clear_model();
        m_busy = 1'b0;
        access("vga_1234", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 14'h1234);
        check("vga_1234_zero", vga_rd, 32'h0);

        // DRAM byte-enable merge
        access("wr_full", 1'b1, 1'b1, 4'hF, 32'h0010, 32'hDEADBEEF, 14'h0);
        access("wr_half", 1'b1, 1'b1, 4'h3, 32'h0010, 32'h11223344, 14'h0);
        access("wr_be0", 1'b1, 1'b1, 4'h0, 32'h0010, 32'hFFFFFFFF, 14'h0);
        access("rd_10", 1'b1, 1'b0, 4'h0, 32'h0010, 32'h0, 14'h0);
        check("rd_10_const", rd, 32'hDEAD3344);
        access("idle_hold", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 14'h0);

        // VRAM write with same-cycle video read (read-first)
        access("vwr_5", 1'b1, 1'b1, 4'hF, 32'h4005, 32'hCAFEF00D, 14'd5);
        check("vga_old", vga_rd, 32'h0);
        access("vga_new", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 14'd5);
        check("vga_new_const", vga_rd, 32'hCAFEF00D);
        access("vrd_5", 1'b1, 1'b0, 4'h0, 32'h4005, 32'h0, 14'd5);

        // Clear on request: VRAM write dropped, DRAM proceeds
        clr_req = 1'b1;
        busy_cycles = 0;
        tick();
        clr_req = 1'b0;
        m_busy = 1'b1;
        check("clr_busy", {31'h0, busy}, 32'h1);
        access("busy_vwr", 1'b1, 1'b1, 4'hF, 32'h4007, 32'h12345678, 14'd0);
        access("busy_dwr", 1'b1, 1'b1, 4'hF, 32'h0007, 32'h0BADF00D, 14'd0);
        access("busy_drd", 1'b1, 1'b0, 4'h0, 32'h0007, 32'h0, 14'd0);
        n = 0;
        while (busy === 1'b1 && n < 20000) begin n++; tick(); end
        check("clr_busy_len", busy_cycles, 16384);
        clear_model();
        m_busy = 1'b0;
        access("vga_cleared5", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 14'd5);
        access("vga_cleared7", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 14'd7);

        // Illegal addresses
        access("ill_wr", 1'b1, 1'b1, 4'hF, 32'h8010, 32'h55555555, 14'd0);
        access("ill_rd", 1'b1, 1'b0, 4'h0, 32'h8000, 32'h0, 14'd0);
        access("ill_after", 1'b1, 1'b0, 4'h0, 32'h0010, 32'h0, 14'd0);
        check("ill_nowrite", rd, 32'hDEAD3344);
        access("ill_top", 1'b1, 1'b0, 4'h0, 32'h80000007, 32'h0, 14'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 8; i++) begin
            pool[i] = 32'($urandom_range(0, 16383));
            access("rnd_init", 1'b1, 1'b1, 4'hF, pool[i], $urandom, 14'($urandom));
        end
        for (int i = 0; i < 300; i++) begin
            k = int'($urandom_range(0, 9));
            if (k < 4) addr = pool[$urandom_range(0, 7)];
            else if (k < 8) addr = 32'h4000 | 32'($urandom_range(0, 16383));
            else addr = (32'h8000 << $urandom_range(0, 16)) | 32'($urandom_range(0, 32767));
            access("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   4'($urandom), addr, $urandom, 14'($urandom));
        end

        // Reset mid-clear (counter=100) and mid-read
        access("pre_v3", 1'b1, 1'b1, 4'hF, 32'h4003, 32'hA5A5A5A5, 14'd3);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        m_busy = 1'b1;
        repeat (99) tick();
        access("midclr_rd", 1'b1, 1'b0, 4'h0, 32'h0010, 32'h0, 14'd0);
        reset = 1'b1;
        #1;
        exp_rd = '0;
        check("rst_mid_vld", {31'h0, rd_valid}, 32'h0);
        check("rst_mid_rd", rd, 32'h0);
        check("rst_mid_busy", {31'h0, busy}, 32'h1);
        tick();
        tick();
        reset = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 20000) begin n++; tick(); end
        check("rst_mid_busy_len", n, 16384);
        clear_model();
        m_busy = 1'b0;
        access("vga_v3", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 14'd3);
        check("vga_v3_zero", vga_rd, 32'h0);
        access("post_drd", 1'b1, 1'b0, 4'h0, 32'h0007, 32'h0, 14'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised successor to the current CPU data-memory split.
- Decodes CPU word addresses into a DRAM region and a VRAM region, with byte-enable writes and registered one-cycle reads.
- Replaces the flat VRAM array export with a registered video read port.
- Adds a VRAM clear engine (FSM) that runs after reset and on request. Sits between the ARM core data port and the VGA controller.

Parameters:
- ADDR_W, 32, CPU address width.
- DATA_W, 32, data width; must be a multiple of 8.
- RAM_DEPTH, 16384, DRAM words.
- VRAM_DEPTH, 16384, VRAM words; must not exceed 2**SEL_BIT.
- SEL_BIT, 14, address bit selecting VRAM (1) or DRAM (0).
- CLEAR_VALUE, 0, word written by the clear engine.
- CLEAR_ON_RESET, 1, run a clear automatically after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- en  in  1  CPU access strobe.
- we  in  1  write (1) / read (0); meaningful only when en=1.
- be  in  DATA_W/8  byte enables for writes.
- a  in  ADDR_W  CPU word address.
- wd  in  DATA_W  write data.
- rd  out  DATA_W  registered read data.
- rd_valid  out  1  rd valid pulse.
- fault  out  1  one-cycle error pulse.
- busy  out  1  clear engine active.
- clr_req  in  1  start/restart a VRAM clear.
- vga_a  in  $clog2(VRAM_DEPTH)  video read address.
- vga_rd  out  DATA_W  video read data.

Behaviour:
- Reset values: rd=0, rd_valid=0, fault=0, vga_rd=0, clear counter=0. Memory contents are not reset.
- If CLEAR_ON_RESET=1: state=CLEAR and busy=1 during reset. Otherwise state=IDLE and busy=0.
- Decode:
  - idx = a[SEL_BIT-1:0].
  - a[SEL_BIT]=0 selects DRAM; a[SEL_BIT]=1 selects VRAM.
  - Illegal access: any a bit above SEL_BIT set, or idx >= the depth of the selected region.
  - An illegal access is dropped (no write; read gives rd_valid=0) and fault=1 on the next cycle.
- Write (en&we, legal): on the clk edge, write each byte lane i where be[i]=1. be=0 is a legal no-op.
- Read (en&!we, legal):
  - rd and rd_valid=1 are driven on the cycle after the request (latency 1).
  - rd_valid is 0 otherwise; rd holds its last value when rd_valid=0.
- Video port: vga_rd = VRAM[vga_a] registered, latency 1.
  - Read-first: a same-cycle write to the same word returns the old data.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clr_req; counter=0.
  - In CLEAR: write CLEAR_VALUE to VRAM[counter] each cycle and increment the counter.
  - CLEAR -> IDLE after writing word VRAM_DEPTH-1. busy falls on the same edge, so busy spans exactly VRAM_DEPTH cycles.
  - clr_req during CLEAR restarts the counter at 0.
- While busy:
  - The clear engine owns the VRAM write port.
  - A CPU VRAM write is dropped and raises a fault pulse.
  - CPU VRAM reads and all DRAM accesses proceed normally.
  - Video reads return current contents (partially cleared).
- Reset asserted mid-clear aborts the clear immediately. On release the engine restarts from 0 if CLEAR_ON_RESET=1.
- Reset asserted mid-read: rd_valid goes to 0 immediately.

Optional Feature:
- DMEM_PARITY_EN defined:
  - Each stored byte carries an even-parity bit, computed on write (CPU and clear engine).
  - Parity is checked on CPU reads. On a mismatch, the read completes with rd_valid=1 and a parity_err output (1 bit, reset 0) pulses with the same timing as rd_valid.
- DMEM_PARITY_EN undefined: no parity storage and no parity_err port.

Decomposition:
- arm_const package gains:
  - a typedef enum for the FSM state (DMEM_IDLE, DMEM_CLEAR);
  - a region typedef (REG_DRAM, REG_VRAM);
  - a DMEM_BE_W constant derived from DATA_W.
- One sub-module, dmem_bank, instantiated twice (DRAM, VRAM): a parametrised true-dual-port byte-enable RAM with one write/read port and one read-only port, read-first.
- Decode, clear FSM and fault logic stay at top level.

Test Plan:
- Reset with CLEAR_ON_RESET=1, release, wait -> busy=1 for exactly 16384 cycles; then vga_a=0x1234 returns vga_rd=0x00000000.
- Write a=0x0010, wd=0xDEADBEEF, be=0xF; then write wd=0x11223344, be=0x3; then read a=0x0010 -> one cycle later rd=0xDEAD3344, rd_valid=1.
- Write a=0x4005, wd=0xCAFEF00D to VRAM while idle; same cycle vga_a=5 -> vga_rd shows old value; next cycle vga_a=5 -> vga_rd=0xCAFEF00D.
- Pulse clr_req, then CPU write to a=0x4007 while busy -> write dropped, fault=1 one cycle later; DRAM write to a=0x0007 in the next cycle succeeds.
- Access a=0x8000 (bit above SEL_BIT set) -> no write, rd_valid=0, fault=1 for one cycle.
- Assert reset at clear counter=100, release -> busy=1 and the clear restarts from word 0 (16384 cycles).
